// File: rtl/gray_pkg.sv
// Shared definitions for the grayscale frame controller: mode codes, channel weights,
// FSM states and coordinate width.
package gray_pkg;

  localparam int COORD_W = 11;

  localparam logic [1:0] MODE_LUMA = 2'b00;
  localparam logic [1:0] MODE_RED  = 2'b01;
  localparam logic [1:0] MODE_MEAN = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  // Weights are unsigned, scale 1/128; each set sums to 128.
  localparam logic [7:0] LUMA_R = 8'd38;
  localparam logic [7:0] LUMA_G = 8'd75;
  localparam logic [7:0] LUMA_B = 8'd15;
  localparam logic [7:0] RED_R  = 8'd128;
  localparam logic [7:0] MEAN_R = 8'd43;
  localparam logic [7:0] MEAN_G = 8'd43;
  localparam logic [7:0] MEAN_B = 8'd42;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LINE,
    ST_GAP,
    ST_FDONE
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       pass;
  } coef_t;

  function automatic coef_t mode_coef(input logic [1:0] mode);
    coef_t c;
    c = '{r: LUMA_R, g: LUMA_G, b: LUMA_B, pass: 1'b0};
    case (mode)
      MODE_RED:  c = '{r: RED_R, g: 8'd0, b: 8'd0, pass: 1'b0};
      MODE_MEAN: c = '{r: MEAN_R, g: MEAN_G, b: MEAN_B, pass: 1'b0};
      MODE_PASS: c = '{r: 8'd0, g: 8'd0, b: 8'd0, pass: 1'b1};
      default:   c = '{r: LUMA_R, g: LUMA_G, b: LUMA_B, pass: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gray_frame_ctrl_sw_debounce.sv
// Two-flop synchronizer plus stability counter for an asynchronous switch bus.
// A value held DEB_CYC cycles after synchronization becomes the pending value; pend_nxt_o is its next state.
module sw_debounce
  import gray_pkg::*;
#(
  parameter int W       = 2,
  parameter int DEB_CYC = 1000000
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] pend_nxt_o
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);

  logic [W-1:0]     sync1_q, sync2_q;
  logic [W-1:0]     cand_q, cand_d;
  logic [W-1:0]     pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter saturates once the candidate is accepted, so pend_q keeps being refreshed with the same value.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
      pend_d = cand_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign pend_nxt_o = pend_d;

endmodule

// File: rtl/gray_frame_ctrl.sv
// Frame controller beside the RGB-to-gray datapath: frame-synchronous mode/coefficient switching,
// pixel coordinates one cycle after iDVAL, frame pulses, frame count and sticky error.
module gray_frame_ctrl
  import gray_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DEB_CYC  = 1000000,
  parameter int GAP_MAX  = 4095
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iDVAL,
  input  logic               iSW4,
  input  logic               iSW5,
  output logic [1:0]         oMode,
  output logic [7:0]         oCoefR,
  output logic [7:0]         oCoefG,
  output logic [7:0]         oCoefB,
  output logic               oPassThru,
  output logic               oPixVal,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  output logic               oFrameStart,
  output logic               oFrameDone,
  output logic [15:0]        oFrameCnt,
  output logic               oErr
);

  localparam int GAP_W = $clog2(GAP_MAX + 1);

  logic [1:0]         pend_nxt;
  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [1:0]         mode_q, mode_d;
  coef_t              coef_q, coef_d;
  logic [15:0]        fcnt_q, fcnt_d;
  logic               err_q, err_d;
  logic               fstart_q, fstart_d;
  logic               fdone_q, pix_val_q, dval_prev_q;
  logic               rise;

  sw_debounce #(.W(2), .DEB_CYC(DEB_CYC)) u_deb (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .sw_i       ({iSW5, iSW4}),
    .pend_nxt_o (pend_nxt)
  );

  // dval_prev_q resets high so a line already in progress at reset release is not taken as a rise.
  assign rise = iDVAL & ~dval_prev_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    gap_d    = gap_q;
    mode_d   = mode_q;
    coef_d   = coef_q;
    fcnt_d   = fcnt_q;
    err_d    = err_q;
    fstart_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_FDONE: begin
        state_d = ST_IDLE;
        if (state_q == ST_FDONE) fcnt_d = fcnt_q + 16'd1;
        if (rise) begin
          state_d  = ST_LINE;
          mode_d   = pend_nxt;
          coef_d   = mode_coef(pend_nxt);
          x_d      = COORD_W'(1);
          y_d      = '0;
          ox_d     = '0;
          oy_d     = '0;
          fstart_d = 1'b1;
        end
      end
      ST_LINE: begin
        if (iDVAL) begin
          ox_d = x_q;
          oy_d = y_q;
          x_d  = x_q + COORD_W'(1);
        end else begin
          state_d = ST_GAP;
          y_d     = y_q + COORD_W'(1);
          gap_d   = GAP_W'(1);
          if (x_q != COORD_W'(H_ACTIVE)) err_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (y_q == COORD_W'(V_ACTIVE)) begin
          state_d = ST_FDONE;
        end else if (iDVAL) begin
          state_d = ST_LINE;
          x_d     = COORD_W'(1);
          ox_d    = '0;
          oy_d    = y_q;
        end else if (gap_q >= GAP_W'(GAP_MAX)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      gap_q       <= '0;
      mode_q      <= MODE_LUMA;
      coef_q      <= mode_coef(MODE_LUMA);
      fcnt_q      <= '0;
      err_q       <= 1'b0;
      fstart_q    <= 1'b0;
      fdone_q     <= 1'b0;
      pix_val_q   <= 1'b0;
      dval_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      gap_q       <= gap_d;
      mode_q      <= mode_d;
      coef_q      <= coef_d;
      fcnt_q      <= fcnt_d;
      err_q       <= err_d;
      fstart_q    <= fstart_d;
      fdone_q     <= (state_q == ST_FDONE);
      pix_val_q   <= iDVAL;
      dval_prev_q <= iDVAL;
    end
  end

  assign oMode       = mode_q;
  assign oCoefR      = coef_q.r;
  assign oCoefG      = coef_q.g;
  assign oCoefB      = coef_q.b;
  assign oPassThru   = coef_q.pass;
  assign oPixVal     = pix_val_q;
  assign oX          = ox_q;
  assign oY          = oy_q;
  assign oFrameStart = fstart_q;
  assign oFrameDone  = fdone_q;
  assign oFrameCnt   = fcnt_q;
  assign oErr        = err_q;

endmodule

// File: doc/gray_frame_ctrl.md
# gray_frame_ctrl

Frame-level controller for the grayscale conversion stage of the pupil-finder camera pipeline. Sits beside the RGB-to-gray datapath on the same iDVAL pixel stream. It synchronizes and debounces the mode switches iSW4/iSW5 and applies a new mode only at frame boundaries. It drives the coefficient set the datapath uses, and tracks pixel/line position so downstream pupil logic gets per-pixel coordinates and frame pulses.

## Interface
- H_ACTIVE, 640: valid pixels per line
- V_ACTIVE, 480: lines per frame
- DEB_CYC, 1000000: cycles a synchronized switch value must hold before it is accepted
- GAP_MAX, 4095: max iDVAL-low cycles tolerated inside a frame
- iCLK  in  1  pixel clock
- iRST  in  1  asynchronous, active-low reset
- iDVAL  in  1  pixel valid, same stream feeding the gray datapath
- iSW4  in  1  mode bit 0, asynchronous switch
- iSW5  in  1  mode bit 1, asynchronous switch
- oMode  out  2  mode in force for the current frame
- oCoefR / oCoefG / oCoefB  out  8 each  channel weights, unsigned, scale 1/128
- oPassThru  out  1  datapath forwards iRed/iGreen/iBlue unweighted
- oPixVal  out  1  registered copy of iDVAL
- oX  out  11  column of the pixel flagged by oPixVal
- oY  out  11  line of the pixel flagged by oPixVal
- oFrameStart  out  1  one-cycle pulse with the first oPixVal of a frame
- oFrameDone  out  1  one-cycle pulse after the last pixel of line V_ACTIVE-1
- oFrameCnt  out  16  completed frames, wraps
- oErr  out  1  sticky; set on line-length mismatch or gap timeout

## Operation
- Switch path:
  - 2-FF synchronizer per switch, then a debounce counter.
  - The counter restarts whenever the synced pair changes.
  - When the pair has been stable for DEB_CYC cycles, it is written to pend_mode.
- Mode table (R,G,B weights; all sum to 128):
  - 00: luma 38,75,15
  - 01: red only 128,0,0
  - 10: mean 43,43,42
  - 11: pass-through; weights 0,0,0, oPassThru=1
- pend_mode is copied to oMode and the coefficient outputs only when a frame starts. Mid-frame switch changes never alter the running frame.
- FSM states:
  - IDLE: waiting for the first iDVAL rise. On rise: latch mode, x=0, y=0 → LINE.
  - LINE: x increments per valid pixel. On iDVAL fall → GAP; y increments.
  - GAP: counts idle cycles.
    - iDVAL rise with y<V_ACTIVE → LINE, x=0.
    - y==V_ACTIVE → FDONE.
    - Idle count reaches GAP_MAX → oErr=1 → IDLE.
  - FDONE: one cycle. oFrameDone=1, oFrameCnt+1 → IDLE.
- Line check: on iDVAL fall, if the pixel count ≠ H_ACTIVE, set oErr. The line is still counted.
- oErr clears only on reset.

## Timing
- Reset values of all outputs:
  - oMode=00; weights 38,75,15; oPassThru=0.
  - oPixVal=0; oX=0; oY=0.
  - oFrameStart=0; oFrameDone=0; oFrameCnt=0; oErr=0.
  - Internal state: pend_mode=00, debounce counter 0, FSM=IDLE.
- Latency: iDVAL sampled at edge n → oPixVal, oX, oY valid after edge n+1 (1 cycle).
- oFrameStart coincides with oPixVal for pixel (0,0).
- oMode and the coefficients update on the same edge that asserts oFrameStart. They are stable everywhere else.
- The datapath must sample the coefficients one cycle after iDVAL to align with its own register.
- oFrameDone asserts 2 cycles after the falling iDVAL edge of the last line.
- A switch change reaches pend_mode 2 + DEB_CYC cycles after it becomes stable.
- Simultaneous events:
  - pend_mode updating on the same cycle as a frame start: the new value is used.
  - iDVAL rising during FDONE: that pixel starts the next frame. IDLE's rise detection applies within the same cycle.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous). After release, the block resyncs on the next iDVAL rise.

## Structure
- Shared package gray_pkg holds:
  - mode encodings (MODE_LUMA, MODE_RED, MODE_MEAN, MODE_PASS)
  - the weight constants
  - FSM state enum
  - coordinate width 11
- One sub-module, sw_debounce: synchronizer plus stability counter, instantiated once on the 2-bit pair.

## Test plan
- Reset, then 3 frames with H_ACTIVE=8, V_ACTIVE=4, gap 5 → oFrameCnt=3; oX 0..7, oY 0..3; oFrameStart and oFrameDone once per frame each; oErr=0.
- DEB_CYC=16. Set SW=01 mid-frame 0 → coefficients stay 38,75,15 until the frame-1 oFrameStart, then 128,0,0.
- SW toggled every 10 cycles, DEB_CYC=16 → pend_mode unchanged; oMode stays 00.
- SW=11 → at the next frame, oPassThru=1 and weights 0,0,0; SW=10 restores 43,43,42 and oPassThru=0.
- One line of 7 pixels → oErr=1 and stays set. The frame still completes with y reaching 4.
- iDVAL low for GAP_MAX+1 mid-frame → oErr=1, FSM in IDLE. The next rise yields oFrameStart with oX=0, oY=0.
- iRST pulsed during line 2 → all outputs at reset values; the next frame counts from (0,0) with oFrameCnt=0.
